ethrx_filt: RTL and testbench

Parametrised Ethernet receive-frame engine, successor of the single-width byte-to-word receiver. It strips preamble/SFD from the RTL8211EG GMII byte stream and packs frame bytes into words of configurable width for the receive buffer RAM, flushing any partial last word. It adds destination-address filtering (station/broadcast/multicast/promiscuous), frame-length checking, and clean resynchronisation after errors. CRC is computed by the external CRC engine; this block sequences it and checks the residue.

---
 rtl/ethrx_filt.sv | 258 +++++++++++++++++++++++++
 tb/tb_ethrx_filt.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethrx_filt.sv
// Ethernet receive-frame engine: strips preamble/SFD from a GMII byte stream, filters on
// destination address, packs bytes little-endian into BW-byte buffer words and checks length/CRC.
module ethrx_filt #(
    parameter int BW     = 4,
    parameter int AW     = 9,
    parameter int NADDR  = 2,
    parameter int PRELEN = 7,
    parameter int MINLEN = 64,
    parameter int MAXLEN = 1518
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  rxena,
    input  logic [7:0]            datain,
    input  logic                  rxdv,
    input  logic                  rxer,
    input  logic [31:0]           crc,
    input  logic                  rxdone,
    input  logic                  promisc,
    input  logic                  allmulti,
    input  logic [48*NADDR-1:0]   staddr,
    input  logic [NADDR-1:0]      staen,
    output logic [10:0]           rxcntb,
    output logic [AW-1:0]         rxbaddr,
    output logic [8*BW-1:0]       rxbdata,
    output logic                  rxwrn,
    output logic                  rxrdy,
    output logic                  rxdrop,
    output logic                  crcen,
    output logic                  crcre,
    output logic                  err_gen,
    output logic                  err_crc,
    output logic                  err_len
);

    localparam int          IW          = $clog2(BW);
    localparam int          PW          = $clog2(PRELEN + 1);
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [10:0] MAXCNT      = 11'(MAXLEN);
    localparam logic [10:0] MINCNT      = 11'(MINLEN);

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA, FLUSH, CHK, FINISH, DISCARD
    } state_t;

    state_t state, state_nxt;

    logic [10:0]     rxcntb_nxt;
    logic [AW-1:0]   rxbaddr_nxt;
    logic [8*BW-1:0] rxbdata_nxt;
    logic            rxwrn_nxt, rxrdy_nxt, rxdrop_nxt, crcen_nxt, crcre_nxt;
    logic            err_gen_nxt, err_crc_nxt, err_len_nxt;
    logic [PW-1:0]   precnt, precnt_nxt;
    logic [IW-1:0]   bidx, bidx_nxt;
    logic            rxdv_p0;
    logic [8*BW-1:0] wbuf_p0, wbuf_nxt;
    logic [39:0]     dest_p0, dest_nxt;
    logic [47:0]     dest_now;
    logic            accept;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        if (v >= MAXCNT) return MAXCNT;
        return v + 11'd1;
    endfunction

    function automatic logic [10:0] sat_sub4(input logic [10:0] v);
        if (v < 11'd4) return 11'd0;
        return v - 11'd4;
    endfunction

    // Destination address completes with the byte currently on datain (6th frame byte).
    always_comb begin
        dest_now = {dest_p0, datain};
        accept   = promisc | (dest_now == 48'hFFFF_FFFF_FFFF) | (dest_now[40] & allmulti);
        for (int i = 0; i < NADDR; i++) begin
            if (staen[i] && (staddr[48*i +: 48] == dest_now)) accept = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        rxcntb_nxt  = rxcntb;
        rxbaddr_nxt = rxbaddr;
        rxbdata_nxt = rxbdata;
        rxwrn_nxt   = 1'b0;
        rxrdy_nxt   = rxrdy;
        rxdrop_nxt  = 1'b0;
        crcen_nxt   = crcen;
        crcre_nxt   = crcre;
        err_gen_nxt = err_gen;
        err_crc_nxt = err_crc;
        err_len_nxt = err_len;
        precnt_nxt  = precnt;
        bidx_nxt    = bidx;
        wbuf_nxt    = wbuf_p0;
        dest_nxt    = dest_p0;

        case (state)
            IDLE: begin
                crcre_nxt   = 1'b1;
                crcen_nxt   = 1'b0;
                rxcntb_nxt  = '0;
                rxbaddr_nxt = '1;
                precnt_nxt  = '0;
                bidx_nxt    = '0;
                // Only a byte following an idle (rxdv low) cycle may open a frame.
                if (rxdv) begin
                    if (rxena && !rxdv_p0 && datain == 8'h55) begin
                        err_gen_nxt = 1'b0;
                        err_crc_nxt = 1'b0;
                        err_len_nxt = 1'b0;
                        precnt_nxt  = PW'(1);
                        state_nxt   = (PRELEN == 1) ? SFD : PRE;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
            end

            PRE: begin
                if (rxdv && !rxer && datain == 8'h55) begin
                    if (precnt == PW'(PRELEN - 1)) state_nxt = SFD;
                    else                           precnt_nxt = precnt + 1'b1;
                end else begin
                    err_gen_nxt = 1'b1;
                    state_nxt   = DISCARD;
                end
            end

            SFD: begin
                if (rxdv && !rxer && datain == 8'hD5) begin
                    crcen_nxt = 1'b1;
                    crcre_nxt = 1'b0;
                    bidx_nxt  = '0;
                    wbuf_nxt  = '0;
                    state_nxt = DATA;
                end else begin
                    err_gen_nxt = 1'b1;
                    state_nxt   = DISCARD;
                end
            end

            DATA: begin
                if (!rxdv) begin
                    crcen_nxt = 1'b0;
                    if (bidx != '0) begin
                        // Upper lanes of wbuf are already zero; the flush write is issued here.
                        rxbdata_nxt = wbuf_p0;
                        rxbaddr_nxt = rxbaddr + 1'b1;
                        rxwrn_nxt   = 1'b1;
                        state_nxt   = FLUSH;
                    end else begin
                        state_nxt = CHK;
                    end
                end else if (rxer) begin
                    err_gen_nxt = 1'b1;
                    crcen_nxt   = 1'b0;
                    state_nxt   = DISCARD;
                end else if (rxcntb == 11'd5 && !accept) begin
                    rxdrop_nxt = 1'b1;
                    crcen_nxt  = 1'b0;
                    state_nxt  = DISCARD;
                end else begin
                    dest_nxt = dest_now[39:0];
                    if (rxcntb == MAXCNT) begin
                        err_len_nxt = 1'b1;
                    end else begin
                        rxcntb_nxt = sat_inc(rxcntb);
                        if (bidx == IW'(BW - 1)) begin
                            rxbdata_nxt                 = wbuf_p0;
                            rxbdata_nxt[8*(BW-1) +: 8]  = datain;
                            rxbaddr_nxt                 = rxbaddr + 1'b1;
                            rxwrn_nxt                   = 1'b1;
                            wbuf_nxt                    = '0;
                            bidx_nxt                    = '0;
                        end else begin
                            wbuf_nxt[8*bidx +: 8] = datain;
                            bidx_nxt              = bidx + 1'b1;
                        end
                    end
                end
            end

            FLUSH: state_nxt = CHK;

            CHK: begin
                rxcntb_nxt = sat_sub4(rxcntb);
                if (crc != CRC_RESIDUE) err_crc_nxt = 1'b1;
                if (rxcntb < MINCNT)    err_len_nxt = 1'b1;
                rxrdy_nxt = 1'b1;
                state_nxt = FINISH;
            end

            FINISH: begin
                if (rxdone) begin
                    rxrdy_nxt = 1'b0;
                    state_nxt = DISCARD;
                end
            end

            DISCARD: begin
                crcen_nxt = 1'b0;
                if (!rxdv) begin
                    crcre_nxt   = 1'b1;
                    rxcntb_nxt  = '0;
                    rxbaddr_nxt = '1;
                    state_nxt   = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: control state and all visible outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            rxcntb  <= '0;
            rxbaddr <= '1;
            rxbdata <= '0;
            rxwrn   <= 1'b0;
            rxrdy   <= 1'b0;
            rxdrop  <= 1'b0;
            crcen   <= 1'b0;
            crcre   <= 1'b1;
            err_gen <= 1'b0;
            err_crc <= 1'b0;
            err_len <= 1'b0;
            precnt  <= '0;
            bidx    <= '0;
            rxdv_p0 <= 1'b1;
        end else begin
            state   <= state_nxt;
            rxcntb  <= rxcntb_nxt;
            rxbaddr <= rxbaddr_nxt;
            rxbdata <= rxbdata_nxt;
            rxwrn   <= rxwrn_nxt;
            rxrdy   <= rxrdy_nxt;
            rxdrop  <= rxdrop_nxt;
            crcen   <= crcen_nxt;
            crcre   <= crcre_nxt;
            err_gen <= err_gen_nxt;
            err_crc <= err_crc_nxt;
            err_len <= err_len_nxt;
            precnt  <= precnt_nxt;
            bidx    <= bidx_nxt;
            rxdv_p0 <= rxdv;
        end
    end

    // Stage p0: packing and address shift registers, re-initialised at every SFD.
    always_ff @(posedge clk) begin
        wbuf_p0 <= wbuf_nxt;
        dest_p0 <= dest_nxt;
    end

endmodule

// File: tb/tb_ethrx_filt.sv
// Directed bench for ethrx_filt: BW=4 main instance plus a BW=2 instance fed the same stream.
module tb_ethrx_filt;

    localparam logic [47:0] ST0   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] ST1   = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;
    localparam logic [31:0] GOOD  = 32'hC704DD7B;

    logic        clk = 1'b0;
    logic        clr, rxena, rxdv, rxer, rxdone, promisc, allmulti;
    logic [7:0]  datain;
    logic [31:0] crc;
    logic [95:0] staddr;
    logic [1:0]  staen;

    logic [10:0] rxcntb, rxcntb2;
    logic [8:0]  rxbaddr, rxbaddr2;
    logic [31:0] rxbdata;
    logic [15:0] rxbdata2;
    logic        rxwrn, rxrdy, rxdrop, crcen, crcre, err_gen, err_crc, err_len;
    logic        rxwrn2, rxrdy2, rxdrop2, crcen2, crcre2, err_gen2, err_crc2, err_len2;

    ethrx_filt #(.BW(4)) u_dut (
        .clk(clk), .clr(clr), .rxena(rxena), .datain(datain), .rxdv(rxdv), .rxer(rxer),
        .crc(crc), .rxdone(rxdone), .promisc(promisc), .allmulti(allmulti),
        .staddr(staddr), .staen(staen), .rxcntb(rxcntb), .rxbaddr(rxbaddr),
        .rxbdata(rxbdata), .rxwrn(rxwrn), .rxrdy(rxrdy), .rxdrop(rxdrop), .crcen(crcen),
        .crcre(crcre), .err_gen(err_gen), .err_crc(err_crc), .err_len(err_len)
    );

    ethrx_filt #(.BW(2)) u_dut2 (
        .clk(clk), .clr(clr), .rxena(rxena), .datain(datain), .rxdv(rxdv), .rxer(rxer),
        .crc(crc), .rxdone(rxdone), .promisc(promisc), .allmulti(allmulti),
        .staddr(staddr), .staen(staen), .rxcntb(rxcntb2), .rxbaddr(rxbaddr2),
        .rxbdata(rxbdata2), .rxwrn(rxwrn2), .rxrdy(rxrdy2), .rxdrop(rxdrop2), .crcen(crcen2),
        .crcre(crcre2), .err_gen(err_gen2), .err_crc(err_crc2), .err_len(err_len2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nwr = 0, nwr2 = 0, ndrop = 0, ncrc = 0, nrdy = 0;
    int nwr_b, nwr2_b, ndrop_b, ncrc_b, nrdy_b;
    int lat;
    logic [8:0]  last_addr = '0;
    logic [31:0] mem [0:511];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (rxwrn) begin
            nwr++;
            last_addr = rxbaddr;
            mem[rxbaddr] = rxbdata;
        end
        if (rxwrn2) nwr2++;
        if (rxdrop) ndrop++;
        if (rxrdy) nrdy++;
        if (crcen && rxdv) ncrc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mark;
        nwr_b = nwr; nwr2_b = nwr2; ndrop_b = ndrop; ncrc_b = ncrc; nrdy_b = nrdy;
    endtask

    task automatic drive(input logic [7:0] b, input logic er);
        datain = b; rxdv = 1'b1; rxer = er;
        tick();
    endtask

    task automatic gap(input int n);
        rxdv = 1'b0; rxer = 1'b0; datain = 8'h00;
        repeat (n) tick();
    endtask

    // Bytes 0..5 carry dst (first wire byte dst[47:40]); byte i>=6 carries i[7:0].
    task automatic run_frame(input int len, input int npre, input int err_at,
                             input int clr_at, input logic [47:0] dst);
        logic [7:0] b;
        mark();
        for (int i = 0; i < npre; i++) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < len; i++) begin
            b = (i < 6) ? dst[47-8*i -: 8] : 8'(i);
            if (i + 1 == clr_at) begin
                clr = 1'b1;
                drive(b, 1'b0);
                clr = 1'b0;
                rxdv = 1'b0;
                return;
            end
            drive(b, (i + 1 == err_at));
        end
        rxdv = 1'b0; rxer = 1'b0; datain = 8'h00;
    endtask

    task automatic wait_ready(output int l);
        l = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rxrdy && l == 0) l = k;
            if (rxrdy && rxrdy2) break;
        end
        chk("rdy_both", {rxrdy, rxrdy2}, 2'b11);
    endtask

    task automatic release_frame;
        rxdone = 1'b1;
        tick();
        rxdone = 1'b0;
        chk("rdy_clear", {rxrdy, rxrdy2}, 2'b00);
        tick();
        chk("idle_addr", rxbaddr, 9'h1FF);
        gap(3);
    endtask

    task automatic rejected(input string tag, input int drops);
        gap(4);
        chk({tag, "_drop"}, ndrop - ndrop_b, drops);
        chk({tag, "_nordy"}, nrdy - nrdy_b, 0);
        chk({tag, "_idle"}, crcre, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; rxena = 1'b1; rxdv = 1'b0; rxer = 1'b0; rxdone = 1'b0;
        promisc = 1'b0; allmulti = 1'b0; datain = 8'h00; crc = GOOD;
        staddr = {ST1, ST0}; staen = 2'b01;
        repeat (3) tick();
        chk("rst_cnt", rxcntb, 11'd0);
        chk("rst_addr", rxbaddr, 9'h1FF);
        chk("rst_ctl", {rxwrn, rxrdy, rxdrop, crcen, crcre}, 5'b00001);
        chk("rst_err", {err_gen, err_crc, err_len}, 3'b000);
        chk("rst_data", rxbdata, 32'h0);
        clr = 1'b0;
        gap(3);

        // Unicast 64-byte good frame
        run_frame(64, 7, 0, 0, ST0);
        wait_ready(lat);
        chk("u64_wr", nwr - nwr_b, 16);
        chk("u64_last", last_addr, 9'd15);
        chk("u64_w0", mem[0], 32'h33221102);
        chk("u64_w15", mem[15], 32'h3F3E3D3C);
        chk("u64_cnt", rxcntb, 11'd60);
        chk("u64_err", {err_gen, err_crc, err_len}, 3'b000);
        chk("u64_lat", lat, 2);
        chk("u64_crcb", ncrc - ncrc_b, 64);
        chk("u64_wr2", nwr2 - nwr2_b, 32);
        release_frame();

        // 65-byte frame: partial last word flushed
        run_frame(65, 7, 0, 0, ST0);
        wait_ready(lat);
        chk("u65_wr", nwr - nwr_b, 17);
        chk("u65_flush", mem[16], 32'h00000040);
        chk("u65_cnt", rxcntb, 11'd61);
        chk("u65_lat", lat, 3);
        chk("u65_wr2", nwr2 - nwr2_b, 33);
        chk("u65_cnt2", rxcntb2, 11'd61);
        release_frame();

        // Address filter
        run_frame(64, 7, 0, 0, ST1);
        rejected("slot1_off", 1);
        promisc = 1'b1;
        run_frame(64, 7, 0, 0, ST1);
        wait_ready(lat);
        chk("promisc_drop", ndrop - ndrop_b, 0);
        release_frame();
        promisc = 1'b0;
        run_frame(64, 7, 0, 0, BCAST);
        wait_ready(lat);
        chk("bcast_wr", nwr - nwr_b, 16);
        release_frame();
        run_frame(64, 7, 0, 0, MCAST);
        rejected("mcast_off", 1);
        allmulti = 1'b1;
        run_frame(64, 7, 0, 0, MCAST);
        wait_ready(lat);
        chk("mcast_drop", ndrop - ndrop_b, 0);
        release_frame();
        allmulti = 1'b0;

        // rxer mid-frame, then recovery
        run_frame(64, 7, 20, 0, ST0);
        rejected("rxer", 0);
        chk("rxer_gen", err_gen, 1'b1);
        run_frame(64, 7, 0, 0, ST0);
        wait_ready(lat);
        chk("recov_err", {err_gen, err_crc, err_len}, 3'b000);
        release_frame();

        // Bad CRC residue
        crc = 32'hDEADBEEF;
        run_frame(64, 7, 0, 0, ST0);
        wait_ready(lat);
        chk("crc_err", {err_gen, err_crc, err_len}, 3'b010);
        release_frame();
        crc = GOOD;

        // Runt frame
        run_frame(40, 7, 0, 0, ST0);
        wait_ready(lat);
        chk("runt_err", {err_gen, err_crc, err_len}, 3'b001);
        chk("runt_cnt", rxcntb, 11'd36);
        release_frame();

        // Overlength frame
        run_frame(1530, 7, 0, 0, ST0);
        wait_ready(lat);
        chk("long_err", err_len, 1'b1);
        chk("long_last", last_addr, 9'd379);
        chk("long_wr", nwr - nwr_b, 380);
        chk("long_cnt", rxcntb, 11'd1514);
        chk("long_wr2", nwr2 - nwr2_b, 759);
        release_frame();

        // Reset mid-frame
        run_frame(64, 7, 0, 30, ST0);
        chk("clr_cnt", rxcntb, 11'd0);
        chk("clr_addr", rxbaddr, 9'h1FF);
        chk("clr_ctl", {rxwrn, rxrdy, crcen, crcre}, 4'b0001);
        gap(4);
        chk("clr_nordy", nrdy - nrdy_b, 0);

        // Short preamble, then a good frame
        run_frame(64, 5, 0, 0, ST0);
        rejected("pre5", 0);
        chk("pre5_gen", err_gen, 1'b1);
        run_frame(64, 7, 0, 0, ST0);
        wait_ready(lat);
        chk("after_cnt", rxcntb, 11'd60);
        chk("after_err", {err_gen, err_crc, err_len}, 3'b000);
        chk("after_wr", nwr - nwr_b, 16);
        release_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
